// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial add/sub datapath.
package addsub_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;
  localparam int NSLICE    = DEF_WIDTH / DEF_SLICE;

  localparam logic [DEF_WIDTH-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DEF_WIDTH-1:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addsub_state_t;
endpackage

// File: rtl/addsub_slice4.sv
// Combinational 4-bit add slice; exposes the carry into bit 3 for overflow detection.
module addsub_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       c_msb
);
  logic [3:0] lo;

  always_comb begin
    lo    = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
    c_msb = lo[3];
    sum   = {a[3] ^ b[3] ^ c_msb, lo[2:0]};
    cout  = (a[3] & b[3]) | (c_msb & (a[3] ^ b[3]));
  end
endmodule

// File: rtl/addsub_16bit_seq.sv
// Nibble-serial signed adder/subtractor with overflow, zero and optional saturation.
//   state | meaning
//   IDLE  | waiting for start; operands latched on acceptance
//   RUN   | one nibble per cycle, LSB first
//   DONE  | one-cycle done pulse, results held
module addsub_16bit_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_sub,
  input  logic             sat_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovfl,
  output logic             zero
);
  localparam int NS = WIDTH / SLICE;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  addsub_state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh, part;
  logic [IW-1:0]    idx;
  logic             carry, sub_l, sat_l, a_msb;

  logic [SLICE-1:0] s_b, s_sum;
  logic             s_cin, s_cout, s_cmsb, last, ov;
  logic [WIDTH-1:0] res_raw, res_final;

  addsub_slice4 u_slice (
    .a     (a_sh[SLICE-1:0]),
    .b     (s_b),
    .cin   (s_cin),
    .sum   (s_sum),
    .cout  (s_cout),
    .c_msb (s_cmsb)
  );

  always_comb begin
    s_b       = b_sh[SLICE-1:0] ^ {SLICE{sub_l}};
    s_cin     = (idx == '0) ? sub_l : carry;
    last      = (idx == IW'(NS - 1));
    res_raw   = {s_sum, part[WIDTH-1:SLICE]};
    ov        = s_cmsb ^ s_cout;
    res_final = res_raw;
    if (sat_l && ov)
      res_final = a_msb ? SAT_NEG : SAT_POS;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      part   <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      sub_l  <= 1'b0;
      sat_l  <= 1'b0;
      a_msb  <= 1'b0;
      result <= '0;
      ovfl   <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= b;
          sub_l <= is_sub;
          sat_l <= sat_en;
          a_msb <= a[WIDTH-1];
          idx   <= '0;
          carry <= 1'b0;
        end
        RUN: begin
          a_sh  <= a_sh >> SLICE;
          b_sh  <= b_sh >> SLICE;
          part  <= res_raw;
          carry <= s_cout;
          idx   <= idx + 1'b1;
          if (last) begin
            result <= res_final;
            ovfl   <= ov;
            zero   <= (res_final == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_addsub_16bit_seq.sv
// Directed bench for addsub_16bit_seq: latency, arithmetic, saturation, ignored start, reset abort.
module tb_addsub_16bit_seq;
  logic        clk = 1'b0;
  logic        rst, start, is_sub, sat_en;
  logic [15:0] a, b;
  logic        busy, done, ovfl, zero;
  logic [15:0] result;

  int total = 0;
  int bad   = 0;

  addsub_16bit_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .is_sub (is_sub),
    .sat_en (sat_en),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovfl   (ovfl),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one operation at a negedge and checks latency, busy width, done pulse and results.
  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vsub, input logic vsat, input logic [15:0] er,
                        input logic eo, input logic ez);
    int cyc, busy_cnt, done_cnt;
    a = va; b = vb; is_sub = vsub; sat_en = vsat; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~va; b = ~vb; is_sub = ~vsub; sat_en = ~vsat;
    cyc = 0; busy_cnt = 0; done_cnt = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, 4);
    check({tag, "_busy_cycles"}, busy_cnt, 4);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_result"}, result, er);
    check({tag, "_ovfl"}, ovfl, eo);
    check({tag, "_zero"}, zero, ez);
    for (int i = 0; i < 4; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_held"}, result, er);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; is_sub = 1'b0; sat_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 16'h0000);
    check("rst_ovfl", ovfl, 1'b0);
    check("rst_zero", zero, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add_small",  16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0);
    run_op("sub_borrow", 16'h0100, 16'h0001, 1'b1, 1'b0, 16'h00FF, 1'b0, 1'b0);
    run_op("sub_neg",    16'hFFF8, 16'h0009, 1'b1, 1'b0, 16'hFFEF, 1'b0, 1'b0);
    run_op("pos_ov",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0);
    run_op("pos_ov_sat", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0);
    run_op("neg_ov_sat", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b0);
    run_op("neg_ov",     16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b0);

    // Abort 0x7FFF + 0x7FFF with reset on the second RUN edge; held outputs are nonzero here.
    a = 16'h7FFF; b = 16'h7FFF; is_sub = 1'b0; sat_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_before", busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_result", result, 16'h0000);
    check("abort_ovfl", ovfl, 1'b0);
    check("abort_zero", zero, 1'b0);
    begin
      int dcnt = 0;
      for (int i = 0; i < 8; i++) begin
        if (done || busy) dcnt++;
        @(negedge clk);
      end
      check("abort_no_done", dcnt, 0);
    end
    run_op("after_abort", 16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0);

    // Second start while busy must be ignored and not queued.
    begin
      int cyc = 0, dcnt = 0;
      a = 16'h1234; b = 16'h1234; is_sub = 1'b1; sat_en = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 16'h0001; b = 16'h0001; is_sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 16'hAAAA; b = 16'h5555;
      @(negedge clk);
      a = 16'h0F0F; b = 16'hF0F0;
      while (!done && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      check("ign_latency", cyc, 1);
      check("ign_result", result, 16'h0000);
      check("ign_zero", zero, 1'b1);
      check("ign_ovfl", ovfl, 1'b0);
      for (int i = 0; i < 12; i++) begin
        if (done) dcnt++;
        @(negedge clk);
      end
      check("ign_done_count", dcnt, 1);
      check("ign_idle", busy, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
